spi_result_serializer: RTL
==========================

Name: spi_result_serializer

Overview:
SPI-slave transmitter that returns MatRaptor PE output entries (value, row, col, last) to the host over MISO. It is the return path for the host-side SPI frame receiver that feeds matraptor_core. Entries arrive on a valid/ready stream into a small FIFO. Each host SPI transaction (CS low, 72 SCLKs) shifts out one 72-bit frame. spi_clk and spi_cs_n are oversampled in the core clock domain.

Parameters:
DATA_W, 32, value width
IDX_W, 16, row/col index width
FIFO_DEPTH, 16, entry buffer depth (power of 2, >=2)
FRAME_W, 8+DATA_W+2*IDX_W (72 at defaults), bits per SPI frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  entry valid from PE output stream
in_ready  out  1  FIFO can accept entry
in_val  in  DATA_W  result value
in_row  in  IDX_W  result row
in_col  in  IDX_W  result column
in_last  in  1  final entry of the whole result
spi_clk  in  1  host SPI clock, mode 0, asynchronous
spi_cs_n  in  1  host chip select, active low, asynchronous
spi_miso  out  1  serial data to host
spi_miso_oe  out  1  MISO output enable
fifo_count  out  $clog2(FIFO_DEPTH+1)  entries buffered
frames_sent  out  16  completed data frames, wraps at 0xFFFF->0
last_sent  out  1  sticky: a last-flagged entry has completed transmission

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: in_ready=1 (after reset cycle), spi_miso=0, spi_miso_oe=0, fifo_count=0, frames_sent=0, last_sent=0, FSM=IDLE, shift register=0.
- Frame layout, MSB first: bit71=valid, bit70=last, bits69:64=0, bits63:32=val, bits31:16=row, bits15:0=col.
- Idle frame: all zeros. It is sent when CS falls while the FIFO is empty.
- Synchronisation: spi_clk and spi_cs_n each pass through 2 flops, then an edge detect on the synced values.
- Host constraint: SCLK half-period >= 4 clk cycles.
- FIFO: in_ready = (fifo_count != FIFO_DEPTH).
  - Push on in_valid && in_ready.
  - Push and pop in the same cycle leaves fifo_count unchanged. When full, a pop frees one slot the following cycle (no same-cycle pass-through).
  - FIFO order is preserved.
- FSM:
  - IDLE:
    - Synced CS falling -> LOAD.
    - If CS is already low when rst releases, stay in IDLE until CS is seen high, so no partial frame is ever started.
  - LOAD (1 cycle):
    - Copy the FIFO head into the shift register without popping, or load the idle frame if the FIFO is empty.
    - bit_cnt=0, spi_miso=bit71 -> SHIFT.
    - spi_miso is valid <=3 clk after the pin-level CS fall.
  - SHIFT:
    - On synced SCLK rising: bit_cnt++.
    - On synced SCLK falling: shift left one bit and drive the new MSB on spi_miso.
    - When bit_cnt reaches FRAME_W -> DONE.
    - Synced CS rising before FRAME_W rising edges -> ABORT path: the entry stays in the FIFO, nothing is counted, go to IDLE.
  - DONE:
    - If a data frame was loaded: pop the FIFO once, frames_sent++, and set last_sent if bit70=1.
    - Idle frames never pop or count.
    - spi_miso=0 for any further SCLKs. Wait for synced CS high -> IDLE.
- spi_miso_oe = synced CS low while FSM != IDLE. spi_miso=0 whenever oe=0.
- Entries pushed during SHIFT do not alter the frame in flight.
- Reset mid-frame:
  - Clears the FIFO, counters and last_sent; oe=0 at the next cycle.
  - In-flight data is lost. The host must re-assert CS to read again.

Test Plan:
- Push val=0x3F800000,row=3,col=7,last=1; host runs 72-bit frame -> MISO stream 0xC0_3F800000_0003_0007; frames_sent=1, last_sent=1, fifo_count=0.
- Empty FIFO, host frame -> 72 zero bits, oe high during CS low; frames_sent=0, fifo_count=0.
- One entry buffered, host raises CS after 40 SCLKs -> fifo_count stays 1; next full frame returns identical 72 bits, then fifo_count=0, frames_sent=1.
- Push 17 back-to-back entries (val=i, row=0, col=i) -> in_ready=0 after 16th, 17th held by source; one frame read -> in_ready=1 the cycle after pop; 17 reads return col=0..16 in order.
- fifo_count=5, push coincides with DONE pop -> fifo_count remains 5.
- rst pulsed while CS low at bit 30 of a frame -> oe=0 next cycle, fifo_count=0; no frame while CS stays low; after CS high then low, idle frame is sent.

Source files
------------

// File: rtl/spi_result_serializer.sv
`timescale 1ns/1ps
// spi_result_serializer: SPI-slave (mode 0) transmitter returning PE result
// entries to the host. Entries are queued in a small FIFO; each CS-low
// transaction shifts one FRAME_W-bit frame out on MISO, MSB first.
//   clk, rst            : core clock, synchronous active-high reset
//   in_valid/in_ready   : entry stream handshake
//   in_val/in_row/in_col/in_last : entry payload
//   spi_clk, spi_cs_n   : host SPI clock / chip select (asynchronous)
//   spi_miso, spi_miso_oe : serial data and its output enable
//   fifo_count          : entries buffered
//   frames_sent         : completed data frames (wrapping)
//   last_sent           : sticky, a last-flagged entry has been sent
module spi_result_serializer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IDX_W      = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FRAME_W    = 8 + DATA_W + 2 * IDX_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_val,
  input  logic [IDX_W-1:0]                  in_row,
  input  logic [IDX_W-1:0]                  in_col,
  input  logic                              in_last,
  input  logic                              spi_clk,
  input  logic                              spi_cs_n,
  output logic                              spi_miso,
  output logic                              spi_miso_oe,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic [15:0]                       frames_sent,
  output logic                              last_sent
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned ENTRY_W = 1 + DATA_W + 2 * IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t state;

  // --------------------------------------------------------------------
  // Input synchronisers and edge detection
  // --------------------------------------------------------------------
  logic sclk_s1, sclk_s2, sclk_d;
  logic cs_s1, cs_s2, cs_d;

  // CS synchroniser resets low: a CS already low at reset release never
  // produces a falling edge until it has been seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      cs_d    <= 1'b0;
    end else begin
      sclk_s1 <= spi_clk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= spi_cs_n;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  always_comb begin
    sclk_rise = sclk_s2 & ~sclk_d;
    sclk_fall = ~sclk_s2 & sclk_d;
    cs_fall   = ~cs_s2 & cs_d;
    cs_rise   = cs_s2 & ~cs_d;
  end

  // --------------------------------------------------------------------
  // Entry FIFO
  // --------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push, pop, commit;
  logic [ENTRY_W-1:0] head;
  logic               fifo_empty;
  logic [FRAME_W-1:0] frame_data;

  always_comb begin
    in_ready   = (count != CNT_W'(FIFO_DEPTH));
    push       = in_valid & in_ready;
    pop        = (state == ST_DONE) & commit;
    fifo_empty = (count == '0);
    head       = mem[rd_ptr];
    frame_data = {1'b1, head[ENTRY_W-1], 6'b0, head[ENTRY_W-2:0]};
    fifo_count = count;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_last, in_val, in_row, in_col};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------
  logic [FRAME_W-1:0] shreg;
  logic [BIT_W-1:0]   bit_cnt;
  logic               miso_q;
  logic               loaded_data;
  logic               loaded_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      miso_q      <= 1'b0;
      loaded_data <= 1'b0;
      loaded_last <= 1'b0;
      commit      <= 1'b0;
      frames_sent <= '0;
      last_sent   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          miso_q <= 1'b0;
          // The frame is captured on the IDLE->LOAD transition so MISO
          // carries bit 71 within 3 clk of the pin-level CS fall.
          if (cs_fall) begin
            state       <= ST_LOAD;
            bit_cnt     <= '0;
            loaded_data <= ~fifo_empty;
            loaded_last <= ~fifo_empty & head[ENTRY_W-1];
            if (fifo_empty) begin
              shreg  <= '0;
              miso_q <= 1'b0;
            end else begin
              shreg  <= frame_data;
              miso_q <= frame_data[FRAME_W-1];
            end
          end
        end
        ST_LOAD: begin
          if (cs_rise) begin
            state  <= ST_IDLE;
            miso_q <= 1'b0;
          end else begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state  <= ST_IDLE;
            miso_q <= 1'b0;
          end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
              state  <= ST_DONE;
              miso_q <= 1'b0;
              commit <= loaded_data;
            end
          end else if (sclk_fall) begin
            shreg  <= {shreg[FRAME_W-2:0], 1'b0};
            miso_q <= shreg[FRAME_W-2];
          end
        end
        ST_DONE: begin
          miso_q <= 1'b0;
          if (commit) begin
            commit      <= 1'b0;
            frames_sent <= frames_sent + 16'd1;
            last_sent   <= last_sent | loaded_last;
          end
          if (cs_rise) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          miso_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    spi_miso_oe = ~cs_s2 & (state != ST_IDLE);
    spi_miso    = spi_miso_oe & miso_q;
  end

endmodule
